tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
- REQ-001: Parameter NCH, default 4: number of time-division channels (slots per frame), legal range 2..16.
- REQ-002: Parameter W, default 8: bits per slot sample.
- REQ-003: clk  input  1  single clock; all state changes on its rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-005: din  input  W  serial slot sample from the upstream TDM multiplexer.
- REQ-006: din_vld  input  1  din carries a valid slot sample this cycle.
- REQ-007: fsync  input  1  frame sync, qualified by din_vld; marks the current sample as slot 0.
- REQ-008: ch_data  output  NCH*W  registered per-channel sample; channel k occupies bits [k*W+W-1 : k*W].
- REQ-009: ch_vld  output  NCH  one-cycle strobe per channel: ch_data slice k was updated.
- REQ-010: frame_done  output  1  one-cycle pulse when the last slot (NCH-1) of a frame is delivered.
- REQ-011: locked  output  1  high while the frame alignment FSM is in LOCK.
- REQ-012: sync_err  output  1  one-cycle pulse on any frame alignment violation.

Function
- REQ-013: The FSM has two states, HUNT and LOCK, and holds a slot counter of width clog2(NCH).
- REQ-014: In HUNT, samples with din_vld=1 and fsync=0 are discarded; no ch_vld is asserted.
- REQ-015: In HUNT, din_vld=1 with fsync=1 accepts the sample as slot 0, sets slot counter to 1, and moves the FSM to LOCK.
- REQ-016: In LOCK, each din_vld=1 sample is written to channel slot_cnt; the counter then increments and wraps from NCH-1 to 0.
- REQ-017: Latency: a sample accepted at edge t appears on ch_data, with the matching ch_vld bit high, after edge t+1; only that channel's slice changes.
- REQ-018: Non-addressed ch_data slices hold their value; ch_vld bits are zero in every cycle without a delivery.
- REQ-019: frame_done pulses in the same cycle as ch_vld[NCH-1].
- REQ-020: In LOCK, din_vld=0 cycles do not advance the counter (gaps of any length are legal).
- REQ-021: In LOCK, fsync=1 with slot_cnt!=0 (early sync): pulse sync_err, accept the sample as slot 0, set counter to 1, remain in LOCK.
- REQ-022: In LOCK, slot_cnt==0 with fsync=0 (missing sync): pulse sync_err, discard the sample, return to HUNT, deassert locked.
- REQ-023: fsync with din_vld=0 is ignored in both states.
- REQ-024: locked is registered and follows the FSM state; it rises on the edge that accepts the first slot 0.

Reset
- REQ-025: rst_n=0 asynchronously forces HUNT, slot counter 0, ch_data all zero, ch_vld 0, frame_done 0, sync_err 0, locked 0.
- REQ-026: Reset mid-frame discards the partial frame; after release the block requires a new fsync before delivering data.

Configuration
- REQ-027: With macro TDM_DEMUX_FRAME_CNT_EN defined, the block adds output frame_cnt (16 bits), which increments on each frame_done and wraps from 0xFFFF to 0, and is cleared by reset and on each HUNT->LOCK transition.
- REQ-028: Without TDM_DEMUX_FRAME_CNT_EN, the frame_cnt port and its logic do not exist, and all other behaviour is identical.

Verification (NCH=4, W=8)
- REQ-029: After reset, drive 0x11 with fsync=1 and then 0x22, 0x33, 0x44 -> ch_vld strobes 0001, 0010, 0100, 1000 on successive cycles; ch_data=0x44332211; frame_done with the last strobe; locked=1.
- REQ-030: Before any fsync, drive 3 samples -> no ch_vld and locked=0; then drive fsync -> lock is acquired on that sample.
- REQ-031: In LOCK, fsync on slot 2 with din=0xAA -> sync_err pulse, ch_vld=0001, ch_data[7:0]=0xAA, locked stays 1.
- REQ-032: In LOCK, complete a frame, then drive the next sample without fsync -> sync_err pulse, no ch_vld, locked=0.
- REQ-033: Insert 5-cycle din_vld gaps between slots, plus fsync pulses with din_vld=0 -> deliveries and slot order are unchanged.
- REQ-034: Assert rst_n=0 after slot 1 -> all outputs clear immediately; with TDM_DEMUX_FRAME_CNT_EN, after 3 full frames frame_cnt=3.

Source files
------------

// File: rtl/tdm_demux.sv
// TDM frame demultiplexer: aligns to fsync, steers each slot sample into its channel register.
// Optional 16-bit frame counter output is built when TDM_DEMUX_FRAME_CNT_EN is defined.
module tdm_demux #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W-1:0]       din,
  input  logic               din_vld,
  input  logic               fsync,
  output logic [NCH*W-1:0]   ch_data,
  output logic [NCH-1:0]     ch_vld,
  output logic               frame_done,
  output logic               locked,
`ifdef TDM_DEMUX_FRAME_CNT_EN
  output logic               sync_err,
  output logic [15:0]        frame_cnt
`else
  output logic               sync_err
`endif
);

  localparam int unsigned CW = $clog2(NCH);
  localparam logic [CW-1:0] LastSlot = CW'(NCH - 1);

  typedef enum logic {StHunt, StLock} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     slot_q, slot_d;
  logic [NCH*W-1:0]  data_q, data_d;
  logic [NCH-1:0]    vld_q, vld_d;
  logic              fd_q, fd_d;
  logic              err_q, err_d;
  logic              wr_en;
  logic [CW-1:0]     wr_slot;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    wr_en   = 1'b0;
    wr_slot = '0;
    err_d   = 1'b0;
    if (din_vld) begin
      unique case (state_q)
        StHunt: begin
          if (fsync) begin
            wr_en   = 1'b1;
            slot_d  = CW'(1);
            state_d = StLock;
          end
        end
        StLock: begin
          if (fsync) begin
            // Early sync realigns the frame but keeps lock.
            err_d  = (slot_q != '0);
            wr_en  = 1'b1;
            slot_d = CW'(1);
          end else if (slot_q == '0) begin
            err_d   = 1'b1;
            state_d = StHunt;
          end else begin
            wr_en   = 1'b1;
            wr_slot = slot_q;
            slot_d  = (slot_q == LastSlot) ? '0 : slot_q + CW'(1);
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      data_d[int'(wr_slot)*W +: W] = din;
    end
    vld_d = wr_en ? (NCH'(1) << wr_slot) : '0;
    fd_d  = wr_en && (wr_slot == LastSlot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHunt;
      slot_q  <= '0;
      data_q  <= '0;
      vld_q   <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign ch_data    = data_q;
  assign ch_vld     = vld_q;
  assign frame_done = fd_q;
  assign sync_err   = err_q;
  assign locked     = (state_q == StLock);

`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [15:0] fc_q, fc_d;

  always_comb begin
    fc_d = fc_q;
    if (state_q == StHunt && state_d == StLock) begin
      fc_d = '0;
    end else if (fd_d) begin
      fc_d = fc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_d;
    end
  end

  assign frame_cnt = fc_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized + directed bench for tdm_demux with a queue-based scoreboard and a slot-level model.
module tb_tdm_demux;
  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     din = '0;
  logic             din_vld = 1'b0;
  logic             fsync = 1'b0;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ch_vld;
  logic             frame_done;
  logic             locked;
  logic             sync_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_vld    (din_vld),
    .fsync      (fsync),
    .ch_data    (ch_data),
    .ch_vld     (ch_vld),
    .frame_done (frame_done),
    .locked     (locked),
`ifdef TDM_DEMUX_FRAME_CNT_EN
    .sync_err   (sync_err),
    .frame_cnt  (frame_cnt)
`else
    .sync_err   (sync_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic [NCH-1:0]   vld;
    logic [NCH*W-1:0] data;
    logic             fd;
    logic             err;
    logic             lk;
    logic [15:0]      fc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: lock flag, next expected slot, channel contents, frame count.
  bit         m_lock = 1'b0;
  int         m_slot = 0;
  logic [W-1:0] m_data[NCH];
  int         m_fc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [NCH*W-1:0] pack_model();
    logic [NCH*W-1:0] p;
    for (int k = 0; k < NCH; k++) p[k*W +: W] = m_data[k];
    return p;
  endfunction

  task automatic step(input bit v, input bit f, input logic [W-1:0] d);
    ev_t e;
    bit dlv = 1'b0;
    bit err = 1'b0;
    int s = 0;
    din_vld = v;
    fsync   = f;
    din     = d;
    if (v) begin
      if (!m_lock) begin
        if (f) begin
          dlv = 1'b1; s = 0; m_lock = 1'b1; m_slot = 1; m_fc = 0;
        end
      end else if (f) begin
        err = (m_slot != 0); dlv = 1'b1; s = 0; m_slot = 1;
      end else if (m_slot == 0) begin
        err = 1'b1; m_lock = 1'b0;
      end else begin
        dlv = 1'b1; s = m_slot; m_slot = (m_slot + 1) % NCH;
      end
    end
    if (dlv) begin
      m_data[s] = d;
      if (s == NCH - 1) m_fc = (m_fc + 1) % 65536;
    end
    if (dlv || err) begin
      e.cyc  = cyc + 1;
      e.vld  = dlv ? (NCH'(1) << s) : '0;
      e.data = pack_model();
      e.fd   = dlv && (s == NCH - 1);
      e.err  = err;
      e.lk   = m_lock;
      e.fc   = 16'(m_fc);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'(i % 2), W'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    din_vld = 1'b0;
    fsync = 1'b0;
    #1;
    chk("rst_ch_data", 64'(ch_data), 64'd0);
    chk("rst_ch_vld", 64'(ch_vld), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_sync_err", 64'(sync_err), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
`ifdef TDM_DEMUX_FRAME_CNT_EN
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
    chk("pending_at_reset", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    m_lock = 1'b0;
    m_slot = 0;
    m_fc   = 0;
    for (int k = 0; k < NCH; k++) m_data[k] = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle the DUT shows an output event, pop and compare.
  always @(negedge clk) begin
    if (rst_n && (ch_vld != '0 || sync_err || frame_done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {58'd0, ch_vld, sync_err, frame_done}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ev_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("ev_ch_vld", 64'(ch_vld), 64'(mon_e.vld));
        chk("ev_ch_data", 64'(ch_data), 64'(mon_e.data));
        chk("ev_frame_done", 64'(frame_done), 64'(mon_e.fd));
        chk("ev_sync_err", 64'(sync_err), 64'(mon_e.err));
        chk("ev_locked", 64'(locked), 64'(mon_e.lk));
`ifdef TDM_DEMUX_FRAME_CNT_EN
        chk("ev_frame_cnt", 64'(frame_cnt), 64'(mon_e.fc));
`endif
      end
    end
  end

  initial begin
    bit v, f;
    for (int k = 0; k < NCH; k++) m_data[k] = '0;
    do_reset();

    // Basic frame
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    step(1'b1, 1'b0, 8'h44);
    chk("frame_data", 64'(ch_data), 64'h44332211);
    chk("frame_last_vld", 64'(ch_vld), 64'h8);
    chk("frame_done", 64'(frame_done), 64'd1);
    chk("frame_locked", 64'(locked), 64'd1);

    // Early sync on slot 2
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b1, 8'hAA);
    chk("early_sync_err", 64'(sync_err), 64'd1);
    chk("early_ch_vld", 64'(ch_vld), 64'h1);
    chk("early_ch0", 64'(ch_data[7:0]), 64'hAA);
    chk("early_locked", 64'(locked), 64'd1);

    // Missing sync after a complete frame
    step(1'b1, 1'b0, 8'hBB);
    step(1'b1, 1'b0, 8'hCC);
    step(1'b1, 1'b0, 8'hDD);
    step(1'b1, 1'b0, 8'hEE);
    chk("missing_sync_err", 64'(sync_err), 64'd1);
    chk("missing_ch_vld", 64'(ch_vld), 64'd0);
    chk("missing_locked", 64'(locked), 64'd0);

    // Hunt discards samples until fsync
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(8'h60 + i));
    chk("hunt_locked", 64'(locked), 64'd0);
    chk("hunt_ch_vld", 64'(ch_vld), 64'd0);
    step(1'b1, 1'b1, 8'h55);
    chk("acquire_locked", 64'(locked), 64'd1);
    chk("acquire_ch_vld", 64'(ch_vld), 64'h1);

    // Gaps with unqualified fsync pulses
    for (int i = 1; i < 2 * NCH; i++) begin
      gap(5);
      step(1'b1, 1'(i % NCH == 0), W'($urandom));
    end

    // Reset mid-frame, then three full frames
    step(1'b1, 1'b1, 8'h70);
    step(1'b1, 1'b0, 8'h71);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(8'h80 + i));
    chk("post_reset_locked", 64'(locked), 64'd0);
    for (int fr = 0; fr < 3; fr++)
      for (int s = 0; s < NCH; s++) step(1'b1, 1'(s == 0), W'($urandom));
`ifdef TDM_DEMUX_FRAME_CNT_EN
    chk("frame_cnt_3", 64'(frame_cnt), 64'd3);
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 9) < 7);
      if (m_lock && m_slot == 0) f = ($urandom_range(0, 9) != 0);
      else f = ($urandom_range(0, 7) == 0);
      step(v, f, W'($urandom));
    end

    gap(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
